// File: rtl/calc_seg_top.sv
// calc_seg_top: accumulator calculator with a multiplexed 7-segment hex display.
//   acc (2*WIDTH bits) is updated as acc <= acc op num1 on a go pulse.
//   ADD/SUB/AND/OR/XOR/SHL complete on the go edge; MUL (shift-add, WIDTH
//   cycles) and DIV (restoring, 2*WIDTH cycles) run iteratively with busy high.
//   Divide by zero sets acc to all-ones and raises the sticky err flag.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   op[2:0]       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 DIV
//   num1          right operand, zero-extended to the accumulator width
//   go, clr       single-cycle command pulses (clr has priority over go)
//   busy, err     MUL/DIV in progress; sticky divide-by-zero flag
//   ans, seg      active-low digit enables and segments {g,f,e,d,c,b,a}
module calc_seg_top #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  num1,
  input  logic              go,
  input  logic              clr,
  output logic              busy,
  output logic              err,
  output logic [DIGITS-1:0] ans,
  output logic [6:0]        seg
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(RW + 1);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] MUL_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(RW - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [RW-1:0] RW_VAL    = RW'(RW);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MUL, OP_DIV
  } op_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // opa: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
  // opb: partial product (MUL) or partial remainder (DIV)
  // opc: remaining multiplier bits (MUL) or divisor (DIV)
  logic [RW-1:0]    opa_q, opa_d;
  logic [RW-1:0]    opb_q, opb_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [DW-1:0]    dig_q, dig_d;

  logic [RW-1:0] b_ext;
  logic [RW-1:0] divisor_ext;
  logic [RW-1:0] prod_nx;
  logic [RW-1:0] rem_sh;
  logic          q_bit;
  logic [3:0]    nib;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;

    b_ext       = {{WIDTH{1'b0}}, num1};
    divisor_ext = {{WIDTH{1'b0}}, opc_q};
    prod_nx     = opb_q + (opc_q[0] ? opa_q : '0);
    rem_sh      = {opb_q[RW-2:0], opa_q[RW-1]};
    q_bit       = (rem_sh >= divisor_ext);

    if (clr) begin
      acc_d   = '0;
      err_d   = 1'b0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            unique case (op_t'(op))
              OP_ADD: acc_d = acc_q + b_ext;
              OP_SUB: acc_d = acc_q - b_ext;
              OP_AND: acc_d = acc_q & b_ext;
              OP_OR:  acc_d = acc_q | b_ext;
              OP_XOR: acc_d = acc_q ^ b_ext;
              OP_SHL: acc_d = (b_ext >= RW_VAL) ? '0 : (acc_q << num1);
              OP_MUL: begin
                opa_d   = acc_q;
                opb_d   = '0;
                opc_d   = num1;
                cnt_d   = '0;
                state_d = S_MUL;
              end
              OP_DIV: begin
                if (num1 == '0) begin
                  acc_d = '1;
                  err_d = 1'b1;
                end else begin
                  opa_d   = acc_q;
                  opb_d   = '0;
                  opc_d   = num1;
                  cnt_d   = '0;
                  state_d = S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          // The last edge commits the sum including the final multiplier bit,
          // so the result lands in acc without an extra cycle.
          opb_d = prod_nx;
          opa_d = opa_q << 1;
          opc_d = opc_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) begin
            acc_d   = prod_nx;
            state_d = S_IDLE;
          end
        end
        S_DIV: begin
          opb_d = q_bit ? (rem_sh - divisor_ext) : rem_sh;
          opa_d = {opa_q[RW-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_LAST) begin
            acc_d   = {opa_q[RW-2:0], q_bit};
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_d = scan_q;
    dig_d  = dig_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

  always_comb begin
    ans = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      ans[i] = (dig_q != DW'(i));
    end
  end

  always_comb begin
    nib = acc_q[4*dig_q +: 4];
    seg = 7'b1111111;
    if (err_q) begin
      seg = 7'b0000110;
    end else begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seg_top.sv
// tb_calc_seg_top: directed bench for calc_seg_top (WIDTH=8, DIGITS=4, SCAN_DIV=4).
// The accumulator is observed only through the scanned display; a cycle
// counter since reset predicts which digit is active at each sample.
module tb_calc_seg_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic [7:0] num1;
  logic       go;
  logic       clr;
  logic       busy;
  logic       err;
  logic [3:0] ans;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int n = 0;

  calc_seg_top #(
    .WIDTH   (8),
    .DIGITS  (4),
    .SCAN_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .op  (op),
    .num1(num1),
    .go  (go),
    .clr (clr),
    .busy(busy),
    .err (err),
    .ans (ans),
    .seg (seg)
  );

  always #5 clk = ~clk;

  // Edges since reset was released.
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op_go(input logic [2:0] o, input logic [7:0] v);
    op   = o;
    num1 = v;
    go   = 1'b1;
    tick();
    go   = 1'b0;
  endtask

  // Check the currently displayed digit against the expected accumulator.
  task automatic chk_now(input string tag, input logic [15:0] acc_exp, input logic err_exp);
    int         d;
    logic [3:0] ans_exp;
    logic [6:0] seg_exp;
    d       = (n / 4) % 4;
    ans_exp = ~(4'b0001 << d);
    seg_exp = err_exp ? 7'b0000110 : hexseg(acc_exp[4*d +: 4]);
    chk({tag, "_ans"}, ans, ans_exp);
    chk({tag, "_seg"}, seg, seg_exp);
  endtask

  // Visit all four digits (one sample per digit hold period).
  task automatic chk_disp(input string tag, input logic [15:0] acc_exp, input logic err_exp);
    for (int k = 0; k < 4; k++) begin
      chk_now(tag, acc_exp, err_exp);
      repeat (4) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op = '0; num1 = '0; go = 1'b0; clr = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ans", ans, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);

    // 1: ADD 0x12
    rst = 1'b0;
    op_go(3'd0, 8'h12);
    chk("add_busy", busy, 1'b0);
    chk("add_ans0", ans, 4'b1110);
    chk("add_seg0", seg, 7'b0100100);
    chk_disp("add", 16'h0012, 1'b0);

    // 2: MUL 0x10 then DIV 7
    op_go(3'd6, 8'h10);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", busy, 1'b1);
      tick();
    end
    chk("mul_done", busy, 1'b0);
    chk_disp("mul", 16'h0120, 1'b0);

    op_go(3'd7, 8'h07);
    for (int i = 0; i < 16; i++) begin
      chk("div_busy", busy, 1'b1);
      tick();
    end
    chk("div_done", busy, 1'b0);
    chk_disp("div", 16'h0029, 1'b0);

    // 3: divide by zero, sticky err, clear
    op_go(3'd7, 8'h00);
    chk("dz_busy", busy, 1'b0);
    chk("dz_err", err, 1'b1);
    chk_disp("dz", 16'hFFFF, 1'b1);
    op_go(3'd0, 8'h01);
    chk("dz_sticky", err, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", err, 1'b0);
    chk_disp("clr", 16'h0000, 1'b0);

    // 4: SUB wrap, SHL out of range, SHL 4
    op_go(3'd1, 8'h01);
    chk_disp("sub", 16'hFFFF, 1'b0);
    op_go(3'd5, 8'd16);
    chk_disp("shl16", 16'h0000, 1'b0);
    op_go(3'd0, 8'h12);
    op_go(3'd5, 8'd4);
    chk_disp("shl4", 16'h0120, 1'b0);

    // logic ops: 0x0120 & 0x31 = 0x20; | 0x0F = 0x2F; ^ 0xFF = 0xD0
    op_go(3'd2, 8'h31);
    op_go(3'd3, 8'h0F);
    op_go(3'd4, 8'hFF);
    chk_disp("logic", 16'h00D0, 1'b0);

    // 5: scan sequence over 0xABCD, every cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    op_go(3'd0, 8'hAB);
    op_go(3'd5, 8'd8);
    op_go(3'd0, 8'hCD);
    for (int i = 0; i < 20; i++) begin
      chk_now("scan", 16'hABCD, 1'b0);
      tick();
    end

    // 6: clr on third MUL cycle aborts
    clr = 1'b1;
    tick();
    clr = 1'b0;
    op_go(3'd0, 8'h12);
    op_go(3'd6, 8'h10);
    tick();
    tick();
    chk("abort_pre", busy, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk_disp("abort", 16'h0000, 1'b0);

    // go while busy is ignored: 5 * 3 = 0xF, stray ADD 1 dropped
    op_go(3'd0, 8'h05);
    op_go(3'd6, 8'h03);
    op_go(3'd0, 8'h01);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("ign_timeout", busy, 1'b0);
    chk_disp("ign", 16'h000F, 1'b0);

    // go and clr on the same edge: clr wins, no MUL starts
    op   = 3'd6;
    num1 = 8'h02;
    go   = 1'b1;
    clr  = 1'b1;
    tick();
    go   = 1'b0;
    clr  = 1'b0;
    chk("goclr_busy", busy, 1'b0);
    chk_disp("goclr", 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
